// File: rtl/ex_mem_if.sv
// EX/MEM stage bus: EX-side instruction fields in, registered MEM-side fields,
// architectural flags, forwarding path and debug counters out.
interface ex_mem_if #(
  parameter int N  = 32,
  parameter int R  = 4,
  parameter int CW = 16
);
  // Handshake: EX advances only in a cycle where ex_ready=1 (ex_ready = !stall).
  // ex_valid qualifies the EX fields; mem_valid qualifies the MEM fields, and
  // MEM control bits are always 0 while mem_valid=0.
  logic          ex_valid;
  logic [N-1:0]  ex_result;
  logic          ex_Z;
  logic          ex_C;
  logic [N-1:0]  ex_writeData;
  logic [R-1:0]  ex_rd;
  logic          ex_regWrite;
  logic          ex_memWrite;
  logic          ex_memToReg;
  logic          ex_setFlags;
  logic          stall;
  logic          flush;
  logic          ex_ready;
  logic          mem_valid;
  logic [N-1:0]  mem_result;
  logic [N-1:0]  mem_writeData;
  logic [R-1:0]  mem_rd;
  logic          mem_regWrite;
  logic          mem_memWrite;
  logic          mem_memToReg;
  logic          flagZ;
  logic          flagC;
  logic          fwd_valid;
  logic [R-1:0]  fwd_rd;
  logic [N-1:0]  fwd_data;
  logic [CW-1:0] stall_count;
  logic          kill_pending;

  modport master (
    output ex_valid, ex_result, ex_Z, ex_C, ex_writeData, ex_rd,
           ex_regWrite, ex_memWrite, ex_memToReg, ex_setFlags, stall, flush,
    input  ex_ready, mem_valid, mem_result, mem_writeData, mem_rd,
           mem_regWrite, mem_memWrite, mem_memToReg, flagZ, flagC,
           fwd_valid, fwd_rd, fwd_data, stall_count, kill_pending
  );

  modport slave (
    input  ex_valid, ex_result, ex_Z, ex_C, ex_writeData, ex_rd,
           ex_regWrite, ex_memWrite, ex_memToReg, ex_setFlags, stall, flush,
    output ex_ready, mem_valid, mem_result, mem_writeData, mem_rd,
           mem_regWrite, mem_memWrite, mem_memToReg, flagZ, flagC,
           fwd_valid, fwd_rd, fwd_data, stall_count, kill_pending
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with stall hold, deferred flush under stall,
// architectural Z/C flags, MEM->EX forwarding and a saturating stall counter.
module ex_mem_stage #(
  parameter int N  = 32,
  parameter int R  = 4,
  parameter int CW = 16
) (
  input logic   clk,
  input logic   rst_n,
  ex_mem_if.slave bus
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          kill_pending;
  logic          kill;
  logic          accept;
  logic          load_valid;
  logic          flag_we;
  logic          mem_valid;
  logic [N-1:0]  mem_result;
  logic [N-1:0]  mem_write_data;
  logic [R-1:0]  mem_rd;
  logic          mem_reg_write;
  logic          mem_mem_write;
  logic          mem_mem_to_reg;
  logic          flag_z;
  logic          flag_c;
  logic [CW-1:0] stall_count;

  // A flush seen while stalled is remembered and applied at the first free cycle.
  assign kill       = bus.flush | kill_pending;
  assign accept     = ~bus.stall & ~kill;
  assign load_valid = accept & bus.ex_valid;
  assign flag_we    = load_valid & bus.ex_setFlags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_write_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      kill_pending   <= 1'b0;
    end else if (!bus.stall) begin
      mem_valid      <= load_valid;
      mem_result     <= bus.ex_result;
      mem_write_data <= bus.ex_writeData;
      mem_rd         <= bus.ex_rd;
      mem_reg_write  <= load_valid & bus.ex_regWrite;
      mem_mem_write  <= load_valid & bus.ex_memWrite;
      mem_mem_to_reg <= load_valid & bus.ex_memToReg;
      kill_pending   <= 1'b0;
    end else if (bus.flush) begin
      kill_pending   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (flag_we) begin
      flag_z <= bus.ex_Z;
      flag_c <= bus.ex_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (bus.stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign bus.ex_ready      = ~bus.stall;
  assign bus.mem_valid     = mem_valid;
  assign bus.mem_result    = mem_result;
  assign bus.mem_writeData = mem_write_data;
  assign bus.mem_rd        = mem_rd;
  assign bus.mem_regWrite  = mem_reg_write;
  assign bus.mem_memWrite  = mem_mem_write;
  assign bus.mem_memToReg  = mem_mem_to_reg;
  assign bus.flagZ         = flag_z;
  assign bus.flagC         = flag_c;
  // Loads are resolved in MEM, so their value is not yet known here.
  assign bus.fwd_valid     = mem_valid & mem_reg_write & ~mem_mem_to_reg & (mem_rd != '0);
  assign bus.fwd_rd        = mem_rd;
  assign bus.fwd_data      = mem_result;
  assign bus.stall_count   = stall_count;
  assign bus.kill_pending  = kill_pending;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, random stream against a
// rule-level model, then async reset and stall-counter saturation.
module tb_ex_mem_stage;
  localparam int N  = 32;
  localparam int R  = 4;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_if #(.N(N), .R(R), .CW(CW)) bus ();
  ex_mem_stage #(.N(N), .R(R), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Reference state: what the MEM register, flags and counters should hold.
  logic          m_valid, m_rw, m_mw, m_mtr, m_z, m_c, m_pend;
  logic [N-1:0]  m_res, m_wd;
  logic [R-1:0]  m_rd;
  int            m_cnt;

  typedef struct {
    logic v; logic [31:0] res; logic z; logic c; logic [3:0] rd;
    logic rw; logic mtr; logic sf; logic st; logic fl;
    logic e_valid; logic [31:0] e_res; logic e_z; logic e_c;
    logic e_rw; logic e_fwd; logic [3:0] e_cnt;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] res, input logic z, input logic c,
                       input logic [N-1:0] wd, input logic [R-1:0] rd, input logic rw,
                       input logic mw, input logic mtr, input logic sf, input logic st,
                       input logic fl);
    bus.ex_valid = v;  bus.ex_result = res; bus.ex_Z = z; bus.ex_C = c;
    bus.ex_writeData = wd; bus.ex_rd = rd; bus.ex_regWrite = rw;
    bus.ex_memWrite = mw; bus.ex_memToReg = mtr; bus.ex_setFlags = sf;
    bus.stall = st; bus.flush = fl;
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0; m_z = 0; m_c = 0; m_pend = 0;
    m_res = '0; m_wd = '0; m_rd = '0; m_cnt = 0;
  endtask

  // One clock of the stage, stated in terms of the architectural rules.
  task automatic model_step();
    logic killed, taken;
    killed = bus.flush || m_pend;
    if (bus.stall) begin
      if (bus.flush) m_pend = 1;
      m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
    end else begin
      taken   = bus.ex_valid && !killed;
      m_valid = taken;
      m_res   = bus.ex_result;
      m_wd    = bus.ex_writeData;
      m_rd    = bus.ex_rd;
      m_rw    = taken && bus.ex_regWrite;
      m_mw    = taken && bus.ex_memWrite;
      m_mtr   = taken && bus.ex_memToReg;
      if (taken && bus.ex_setFlags) begin
        m_z = bus.ex_Z;
        m_c = bus.ex_C;
      end
      m_pend = 0;
    end
  endtask

  task automatic check_model(input string tag);
    logic exp_fwd;
    exp_fwd = m_valid && m_rw && !m_mtr && (m_rd != 0);
    chk({tag, ".mem_valid"},    bus.mem_valid,     m_valid);
    chk({tag, ".mem_result"},   bus.mem_result,    m_res);
    chk({tag, ".mem_wdata"},    bus.mem_writeData, m_wd);
    chk({tag, ".mem_rd"},       bus.mem_rd,        m_rd);
    chk({tag, ".mem_regWrite"}, bus.mem_regWrite,  m_rw);
    chk({tag, ".mem_memWrite"}, bus.mem_memWrite,  m_mw);
    chk({tag, ".mem_memToReg"}, bus.mem_memToReg,  m_mtr);
    chk({tag, ".flagZ"},        bus.flagZ,         m_z);
    chk({tag, ".flagC"},        bus.flagC,         m_c);
    chk({tag, ".fwd_valid"},    bus.fwd_valid,     exp_fwd);
    chk({tag, ".fwd_rd"},       bus.fwd_rd,        m_rd);
    chk({tag, ".fwd_data"},     bus.fwd_data,      m_res);
    chk({tag, ".stall_count"},  bus.stall_count,   m_cnt[CW-1:0]);
    chk({tag, ".kill_pending"}, bus.kill_pending,  m_pend);
  endtask

  // Inputs are driven 1 time unit after an edge; outputs are sampled likewise.
  task automatic tick(input string tag);
    #1;
    chk({tag, ".ex_ready"}, bus.ex_ready, !bus.stall);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    drive(0, '0, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;

    //          v  res           z  c  rd rw mtr sf st fl | valid e_res     z  c  rw fwd cnt
    vt[0]  = '{1, 32'h00000005, 0, 0, 3, 1, 0, 0, 0, 0,  1, 32'h00000005, 0, 0, 1, 1, 0};
    vt[1]  = '{1, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 0,  1, 32'hFFFFFFFF, 0, 0, 1, 0, 0};
    vt[2]  = '{1, 32'h00000000, 1, 1, 2, 1, 1, 1, 0, 0,  1, 32'h00000000, 1, 1, 1, 0, 0};
    vt[3]  = '{1, 32'h00000007, 0, 0, 4, 1, 0, 0, 0, 0,  1, 32'h00000007, 1, 1, 1, 1, 0};
    vt[4]  = '{1, 32'h00001234, 0, 0, 5, 1, 0, 0, 0, 0,  1, 32'h00001234, 1, 1, 1, 1, 0};
    vt[5]  = '{1, 32'hAAAA0001, 0, 0, 7, 1, 0, 1, 1, 0,  1, 32'h00001234, 1, 1, 1, 1, 1};
    vt[6]  = '{1, 32'hAAAA0002, 0, 1, 7, 1, 0, 1, 1, 0,  1, 32'h00001234, 1, 1, 1, 1, 2};
    vt[7]  = '{1, 32'hAAAA0003, 0, 0, 7, 0, 0, 1, 1, 0,  1, 32'h00001234, 1, 1, 1, 1, 3};
    vt[8]  = '{0, 32'hAAAA0004, 0, 0, 7, 1, 0, 1, 1, 0,  1, 32'h00001234, 1, 1, 1, 1, 4};
    vt[9]  = '{1, 32'h0000BEEF, 0, 0, 8, 1, 0, 0, 0, 0,  1, 32'h0000BEEF, 1, 1, 1, 1, 4};
    vt[10] = '{1, 32'h0000DEAD, 0, 0, 9, 1, 0, 1, 1, 1,  1, 32'h0000BEEF, 1, 1, 1, 1, 5};
    vt[11] = '{1, 32'h0000DEAD, 0, 0, 9, 1, 0, 1, 0, 0,  0, 32'h0000DEAD, 1, 1, 0, 0, 5};
    vt[12] = '{1, 32'h00000042, 0, 1, 6, 1, 0, 1, 0, 0,  1, 32'h00000042, 0, 1, 1, 1, 5};
    vt[13] = '{1, 32'h00000009, 0, 0, 6, 1, 0, 0, 0, 1,  0, 32'h00000009, 0, 1, 0, 0, 5};
    vt[14] = '{1, 32'h00000009, 0, 0, 6, 1, 0, 0, 0, 0,  1, 32'h00000009, 0, 1, 1, 1, 5};

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].v, vt[i].res, vt[i].z, vt[i].c, ~vt[i].res, vt[i].rd, vt[i].rw,
            1'b0, vt[i].mtr, vt[i].sf, vt[i].st, vt[i].fl);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_valid", i), bus.mem_valid,    vt[i].e_valid);
      chk($sformatf("vec%0d.t_result", i), bus.mem_result,  vt[i].e_res);
      chk($sformatf("vec%0d.t_flagZ", i), bus.flagZ,        vt[i].e_z);
      chk($sformatf("vec%0d.t_flagC", i), bus.flagC,        vt[i].e_c);
      chk($sformatf("vec%0d.t_regWrite", i), bus.mem_regWrite, vt[i].e_rw);
      chk($sformatf("vec%0d.t_fwd", i), bus.fwd_valid,      vt[i].e_fwd);
      chk($sformatf("vec%0d.t_cnt", i), bus.stall_count,    vt[i].e_cnt);
    end

    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom), $urandom,
            R'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
      tick($sformatf("rnd%0d", i));
    end

    // Asynchronous reset between edges, with stall already asserted.
    drive(1, 32'h55, 1, 1, 32'h66, 4'd3, 1, 1, 0, 1, 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    check_model("in_rst");
    rst_n = 1'b1;
    drive(1, 32'h77, 0, 0, 32'h88, 4'd2, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick($sformatf("sat%0d", i));
    chk("sat.final_count", bus.stall_count, 4'd15);
    chk("sat.valid_empty", bus.mem_valid, 1'b0);

    drive(1, 32'h99, 0, 0, 32'h0, 4'd1, 1, 0, 0, 0, 0, 0);
    tick("post_sat");
    chk("post_sat.result", bus.mem_result, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register between the execute (EX) and memory (MEM) stages of the RSA decryption ASIP datapath. It captures the ALU result, Z/C flags, store data and control bits from EX, and holds them under MEM back-pressure. It squashes killed instructions, keeps the architectural Z/C flag register, and drives a forwarding path back to EX. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- N, 32, datapath width (ALU result, store data)
- R, 4, register address width
- CW, 16, stall counter width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- ex_valid  in  1  EX holds a valid instruction
- ex_result  in  N  ALU result
- ex_Z, ex_C  in  1 each  zero/carry flags from ALU for ex_result
- ex_writeData  in  N  store data
- ex_rd  in  R  destination register
- ex_regWrite, ex_memWrite, ex_memToReg, ex_setFlags  in  1 each  control bits
- stall  in  1  MEM not ready; hold register
- flush  in  1  kill the instruction currently in EX
- ex_ready  out  1  EX may advance this cycle
- mem_valid  out  1  MEM register holds a live instruction
- mem_result, mem_writeData  out  N  registered copies
- mem_rd  out  R  registered destination
- mem_regWrite, mem_memWrite, mem_memToReg  out  1 each  registered control, forced 0 when mem_valid=0
- flagZ, flagC  out  1 each  architectural flags
- fwd_valid  out  1  forwarding available
- fwd_rd  out  R  forwarded register index
- fwd_data  out  N  forwarded value
- stall_count  out  CW  saturating count of stalled cycles

## Operation
- Accept condition: `accept = !stall && !kill`, where `kill = flush | killPending`.
- Loading the register:
  - When !stall: register loads EX fields.
  - mem_valid <= ex_valid && !kill.
  - When the loaded instruction is not valid, regWrite, memWrite and memToReg load 0. Data fields load regardless.
- When stall=1: every data, control, valid and flag bit holds.
- flush with stall=1: register holds. killPending is set so the held EX instruction is killed in the first non-stalled cycle. killPending clears in the cycle it is consumed (stall=0).
- flush with stall=0: kill takes effect immediately. killPending stays 0.
- Flags: flagZ<=ex_Z and flagC<=ex_C only when stall=0, ex_valid=1, kill=0 and ex_setFlags=1. Otherwise they hold. Killed or bubble instructions never alter flags.
- Forwarding (combinational from register):
  - fwd_valid = mem_valid & mem_regWrite & !mem_memToReg & (mem_rd != 0).
  - fwd_rd = mem_rd; fwd_data = mem_result.
  - Load results are never forwarded from this stage.
- ex_ready = !stall (combinational).
- stall_count increments each cycle stall=1 and saturates at 2^CW-1. It never wraps.

## Timing
- Reset (rst_n=0): asynchronous. All outputs, flags, killPending and stall_count go to 0. mem_valid=0 immediately, without waiting for a clock edge.
- First capture is on the first rising edge after rst_n deasserts. Reset released mid-stall restarts from an empty register.
- Latency EX→MEM: 1 cycle; throughput one instruction/cycle when stall=0.
- A stall asserted in cycle t freezes the outputs seen at cycle t+1 for as long as stall stays high. The first new value appears the edge after stall drops.
- Flags are visible to the instruction following the flag-setting one by one cycle, i.e. together with that instruction's mem_valid.
- Back-to-back setFlags instructions: the last accepted one wins. No merging.

## Test plan
- Streaming: 3 valid ops, results 0x00000005, 0xFFFFFFFF, 0x00000000, stall=0 → each appears on mem_result one cycle later with mem_valid=1.
- Flag update: op 0x0 with Z=1,C=1, setFlags=1, then op with setFlags=0 and Z=0 → flagZ=1, flagC=1 after edge 1, unchanged after edge 2.
- Stall hold: mem_result=0x1234, stall high 4 cycles while EX changes → outputs constant 0x1234; stall_count=4; the next EX value appears one edge after stall drops.
- Flush during stall: stall=1 and flush=1 in the same cycle, then stall drops → held MEM contents unchanged while stalled; the next capture gives mem_valid=0, all control 0, flags unchanged. The cycle after, a valid op is accepted normally.
- Forwarding: regWrite=1, rd=3, memToReg=0 → fwd_valid=1, fwd_rd=3. The same with rd=0 or memToReg=1 → fwd_valid=0.
- Async reset mid-stream: rst_n low between edges → all outputs 0 immediately. With CW=4, holding stall for 20 cycles afterwards → stall_count saturates at 15.
